// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction field bundles into 32-bit ARM words,
// queues them in a small FIFO and drains them to the instruction-memory write
// port at auto-incrementing word addresses. A separate checker module holds
// the run-time properties of the write port.

module inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic              in_load,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [15:0]       count,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]    FULL_OCC = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  // Field packing: the inverse of the core's decode field map.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  kind,
    input logic [3:0]  cond,
    input logic [3:0]  opcode,
    input logic        s_bit,
    input logic        load,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [3:0]  rm,
    input logic [23:0] imm
  );
    logic [31:0] word;
    word = 32'h0000_0000;
    word[31:28] = cond;
    case (kind)
      2'd0: begin
        word[27:25] = 3'b101;
        word[24]    = s_bit;       // link bit
        word[23:0]  = imm;
      end
      2'd1: begin
        word[27:25] = 3'b000;
        word[24:21] = opcode;
        word[20]    = s_bit;
        word[19:16] = rn;
        word[15:12] = rd;
        word[3:0]   = rm;
      end
      2'd2: begin
        word[27:25] = 3'b001;
        word[24:21] = opcode;
        word[20]    = s_bit;
        word[19:16] = rn;
        word[15:12] = rd;
        word[11:0]  = imm[11:0];
      end
      2'd3: begin
        word[27:25] = 3'b010;
        word[24]    = 1'b1;        // pre-indexed
        word[23]    = imm[12];     // up/down
        word[22]    = 1'b0;        // word access
        word[21]    = 1'b0;        // no write-back
        word[20]    = load;
        word[19:16] = rn;
        word[15:12] = rd;
        word[11:0]  = imm[11:0];
      end
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Immediate forms only carry 12 (data) or 13 (load/store with U) bits.
  function automatic logic bundle_legal(input logic [1:0] kind, input logic [23:0] imm);
    logic ok;
    case (kind)
      2'd2:    ok = (imm[23:12] == 12'h000);
      2'd3:    ok = (imm[23:13] == 11'h000);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic [31:0]       last_q, last_d;

  logic              empty_s;
  logic              full_s;
  logic              accept_s;
  logic              legal_s;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       word_s;

  assign empty_s   = (occ_q == '0);
  assign full_s    = (occ_q == FULL_OCC);
  assign in_ready  = !full_s && !restart;
  assign mem_we    = !empty_s;
  assign mem_addr  = addr_q;
  assign mem_wdata = empty_s ? last_q : fifo_q[rd_ptr_q];
  assign count     = count_q;
  assign err       = err_q;

  // Handshake decode: legality, push and pop strobes for this cycle.
  always_comb begin
    word_s   = encode_word(in_kind, in_cond, in_opcode, in_s, in_load,
                           in_rn, in_rd, in_rm, in_imm);
    legal_s  = bundle_legal(in_kind, in_imm);
    accept_s = in_valid && in_ready;
    push_s   = accept_s && legal_s;
    pop_s    = mem_we && mem_ready && !restart;
  end

  // Next-state for pointers, occupancy, address, counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    // The visible word is remembered so mem_wdata holds when the FIFO empties
    // and survives a restart.
    last_d   = mem_wdata;
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      addr_d   = BASE_C;
      count_d  = 16'h0000;
      err_d    = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(4);
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'h0001;
        end else begin
          count_d = count_q;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
        2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
        default: occ_d = occ_q;
      endcase
      if (accept_s && !legal_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers with synchronous reset; reset outranks restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      addr_q   <= BASE_C;
      count_q  <= 16'h0000;
      err_q    <= 1'b0;
      last_q   <= 32'h0000_0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage: write the encoded word at the tail on every push.
  always_ff @(posedge clk) begin
    if (push_s && !reset && !restart) begin
      fifo_q[wr_ptr_q] <= word_s;
    end
  end

  inst_encoder_chk #(
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W),
    .DEPTH  (DEPTH)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .in_ready  (in_ready),
    .occ       (occ_q)
  );

endmodule

// Run-time properties of the encoder's FIFO and write port.
module inst_encoder_chk #(
  parameter int ADDR_W = 10,
  parameter int PTR_W  = 2,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              restart,
  input logic              mem_we,
  input logic              mem_ready,
  input logic [ADDR_W-1:0] mem_addr,
  input logic [31:0]       mem_wdata,
  input logic              in_ready,
  input logic [PTR_W:0]    occ
);

  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  // A stalled write keeps its address and data.
  a_hold: assert property (@(posedge clk) disable iff (reset)
    (mem_we && !mem_ready && !restart) |=> ($stable(mem_addr) && $stable(mem_wdata)));

  // Occupancy never exceeds the FIFO size, and a full FIFO never accepts.
  a_occ: assert property (@(posedge clk) disable iff (reset)
    (occ <= FULL_OCC) && !(in_ready && (occ == FULL_OCC)));

  // The write request mirrors a non-empty FIFO.
  a_we: assert property (@(posedge clk) disable iff (reset)
    mem_we == (occ != '0));

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: two instances (10-bit address at base 0 and 4-bit
// address at base 0xC) share one stimulus stream; a queue-based model checks
// every cycle, and directed steps pin the worked encodings and boundaries.
`timescale 1ns/1ps
module tb_inst_encoder;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart, in_valid, mem_ready, in_s, in_load;
  logic [1:0]  in_kind;
  logic [3:0]  in_cond, in_opcode, in_rn, in_rd, in_rm;
  logic [23:0] in_imm;

  logic        a_in_ready, a_mem_we, a_err;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic [15:0] a_count;
  logic        b_in_ready, b_mem_we, b_err;
  logic [3:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [15:0] b_count;

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_kind(in_kind), .in_cond(in_cond),
    .in_opcode(in_opcode), .in_s(in_s), .in_load(in_load), .in_rn(in_rn),
    .in_rd(in_rd), .in_rm(in_rm), .in_imm(in_imm), .mem_we(a_mem_we),
    .mem_ready(mem_ready), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .count(a_count), .err(a_err));

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(12)) dut_b (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_kind(in_kind), .in_cond(in_cond),
    .in_opcode(in_opcode), .in_s(in_s), .in_load(in_load), .in_rn(in_rn),
    .in_rd(in_rd), .in_rm(in_rm), .in_imm(in_imm), .mem_we(b_mem_we),
    .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .count(b_count), .err(b_err));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding built arithmetically from the field positions.
  function automatic logic [31:0] model_word(input logic [1:0] kind, input logic [3:0] cond,
      input logic [3:0] op, input logic s, input logic load, input logic [3:0] rn,
      input logic [3:0] rd, input logic [3:0] rm, input logic [23:0] imm);
    logic [31:0] w;
    logic [31:0] regs;
    w    = 32'(cond) << 28;
    regs = (32'(rn) << 16) | (32'(rd) << 12);
    case (kind)
      2'd0: w = w | (32'd5 << 25) | (32'(s) << 24) | 32'(imm);
      2'd1: w = w | (32'(op) << 21) | (32'(s) << 20) | regs | 32'(rm);
      2'd2: w = w | (32'd1 << 25) | (32'(op) << 21) | (32'(s) << 20) | regs | (32'(imm) % 32'd4096);
      default: w = w | (32'd2 << 25) | (32'd1 << 24) | (32'((imm / 24'd4096) % 24'd2) << 23)
                     | (32'(load) << 20) | regs | (32'(imm) % 32'd4096);
    endcase
    return w;
  endfunction

  function automatic bit model_legal(input logic [1:0] kind, input logic [23:0] imm);
    if (kind == 2'd2) return (imm < 24'd4096);
    if (kind == 2'd3) return (imm < 24'd8192);
    return 1'b1;
  endfunction

  // Behavioural model state
  logic [31:0] mq[$];
  int unsigned m_count;
  bit          m_err;
  int unsigned m_addr_a, m_addr_b;
  logic [31:0] m_last;
  bit          m_valid = 1'b0;
  logic [31:0] shown;
  bit          acc;

  // Compare every cycle on the falling edge, then advance the model with the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin
    shown = (mq.size() != 0) ? mq[0] : m_last;
    if (m_valid) begin
      chk("in_ready_a",  32'(a_in_ready), 32'((mq.size() < DEPTH) && !restart));
      chk("in_ready_b",  32'(b_in_ready), 32'((mq.size() < DEPTH) && !restart));
      chk("mem_we_a",    32'(a_mem_we), 32'(mq.size() != 0));
      chk("mem_we_b",    32'(b_mem_we), 32'(mq.size() != 0));
      chk("mem_wdata_a", a_mem_wdata, shown);
      chk("mem_wdata_b", b_mem_wdata, shown);
      chk("mem_addr_a",  32'(a_mem_addr), m_addr_a);
      chk("mem_addr_b",  32'(b_mem_addr), m_addr_b);
      chk("count_a",     32'(a_count), m_count);
      chk("count_b",     32'(b_count), m_count);
      chk("err_a",       32'(a_err), 32'(m_err));
      chk("err_b",       32'(b_err), 32'(m_err));
    end
    if (reset) begin
      mq.delete(); m_count = 0; m_err = 0; m_addr_a = 0; m_addr_b = 12;
      m_last = 32'h0; m_valid = 1'b1;
    end else if (restart) begin
      m_last = shown;
      mq.delete(); m_count = 0; m_err = 0; m_addr_a = 0; m_addr_b = 12;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      m_last = shown;
      if (mq.size() != 0 && mem_ready) begin
        void'(mq.pop_front());
        m_addr_a = (m_addr_a + 4) % 1024;
        m_addr_b = (m_addr_b + 4) % 16;
        if (m_count < 65535) m_count++;
      end
      if (acc && model_legal(in_kind, in_imm))
        mq.push_back(model_word(in_kind, in_cond, in_opcode, in_s, in_load,
                                in_rn, in_rd, in_rm, in_imm));
      if (acc && !model_legal(in_kind, in_imm)) m_err = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] k, input logic [3:0] c, input logic [3:0] op,
      input logic s, input logic l, input logic [3:0] rn, input logic [3:0] rd,
      input logic [3:0] rm, input logic [23:0] imm);
    in_kind = k; in_cond = c; in_opcode = op; in_s = s; in_load = l;
    in_rn = rn; in_rd = rd; in_rm = rm; in_imm = imm;
  endtask

  task automatic set_random_kind1();
    set_fields(2'd1, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
  endtask

  task automatic send(input logic [1:0] k, input logic [3:0] c, input logic [3:0] op,
      input logic s, input logic l, input logic [3:0] rn, input logic [3:0] rd,
      input logic [3:0] rm, input logic [23:0] imm);
    set_fields(k, c, op, s, l, rn, rd, rm, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  int nacc, nwr, guard, r;
  int exp_a[5] = '{0, 4, 8, 12, 16};
  int exp_b[5] = '{12, 0, 4, 8, 12};

  initial begin
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    set_fields(2'd0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 24'h0);

    // Pin the model against hand-computed words
    chk("model_k1",  model_word(2'd1, 4'hE, 4'h4, 1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 24'h0), 32'hE0912003);
    chk("model_k2",  model_word(2'd2, 4'h0, 4'hD, 1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 24'h0000FF), 32'h03A050FF);
    chk("model_ld",  model_word(2'd3, 4'hE, 4'h0, 1'b0, 1'b1, 4'h4, 4'h6, 4'h0, 24'h001010), 32'hE5946010);
    chk("model_st",  model_word(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 4'h4, 4'h6, 4'h0, 24'h000010), 32'hE5046010);
    chk("model_br",  model_word(2'd0, 4'hA, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 24'hFFFFFE), 32'hABFFFFFE);
    chk("model_ill", 32'(model_legal(2'd2, 24'h001000)), 32'd0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_we",    32'(a_mem_we), 32'd0);
    chk("rst_addr_a", 32'(a_mem_addr), 32'h0);
    chk("rst_addr_b", 32'(b_mem_addr), 32'hC);
    chk("rst_wdata", a_mem_wdata, 32'h0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_err",   32'(a_err), 32'd0);
    chk("rst_ready", 32'(a_in_ready), 32'd1);

    // 1: data-register word, one-cycle latency, then written
    mem_ready = 1'b1;
    send(2'd1, 4'hE, 4'h4, 1'b1, 1'b0, 4'h1, 4'h2, 4'h3, 24'h0);
    chk("t1_we",    32'(a_mem_we), 32'd1);
    chk("t1_addr",  32'(a_mem_addr), 32'h0);
    chk("t1_addr_b", 32'(b_mem_addr), 32'hC);
    chk("t1_wdata", a_mem_wdata, 32'hE0912003);
    step();
    chk("t1_count", 32'(a_count), 32'd1);
    chk("t1_idle",  32'(a_mem_we), 32'd0);
    chk("t1_hold",  a_mem_wdata, 32'hE0912003);

    // 2: data-immediate, then an illegal immediate dropped
    send(2'd2, 4'h0, 4'hD, 1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 24'h0000FF);
    chk("t2_wdata",  a_mem_wdata, 32'h03A050FF);
    chk("t2_wrap_b", 32'(b_mem_addr), 32'h0);
    step();
    send(2'd2, 4'h0, 4'hD, 1'b0, 1'b0, 4'h0, 4'h5, 4'h0, 24'h001000);
    chk("t2_err",   32'(a_err), 32'd1);
    chk("t2_drop",  32'(a_mem_we), 32'd0);
    chk("t2_count", 32'(a_count), 32'd2);

    // 3: load then store
    send(2'd3, 4'hE, 4'h0, 1'b0, 1'b1, 4'h4, 4'h6, 4'h0, 24'h001010);
    chk("t3_load", a_mem_wdata, 32'hE5946010);
    step();
    send(2'd3, 4'hE, 4'h0, 1'b0, 1'b0, 4'h4, 4'h6, 4'h0, 24'h000010);
    chk("t3_store", a_mem_wdata, 32'hE5046010);
    step();

    // 4: branch with link
    send(2'd0, 4'hA, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 24'hFFFFFE);
    chk("t4_branch", a_mem_wdata, 32'hABFFFFFE);
    step();
    chk("t4_count", 32'(a_count), 32'd5);

    // Restart clears counters, error and address but keeps mem_wdata
    restart = 1'b1;
    step();
    restart = 1'b0;
    #1;
    chk("rs_count",  32'(a_count), 32'd0);
    chk("rs_err",    32'(a_err), 32'd0);
    chk("rs_addr_a", 32'(a_mem_addr), 32'h0);
    chk("rs_addr_b", 32'(b_mem_addr), 32'hC);
    chk("rs_wdata",  a_mem_wdata, 32'hABFFFFFE);

    // 5: fill with memory stalled, then drain five words in order
    mem_ready = 1'b0; in_valid = 1'b1; nacc = 0; guard = 0;
    while (nacc < 4 && guard < 20) begin
      set_random_kind1();
      if (a_in_ready) nacc++;
      step();
      guard++;
    end
    chk("t5_full_ready_a", 32'(a_in_ready), 32'd0);
    chk("t5_full_ready_b", 32'(b_in_ready), 32'd0);
    chk("t5_stall_addr",   32'(a_mem_addr), 32'h0);
    mem_ready = 1'b1; nwr = 0; guard = 0;
    while (nwr < 5 && guard < 40) begin
      if (in_valid && a_in_ready) nacc++;
      if (a_mem_we) begin
        chk("t5_addr_a", 32'(a_mem_addr), 32'(exp_a[nwr]));
        chk("t5_addr_b", 32'(b_mem_addr), 32'(exp_b[nwr]));
        nwr++;
      end
      step();
      if (nacc >= 5) in_valid = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    chk("t5_writes", 32'(nwr), 32'd5);
    chk("t5_count",  32'(a_count), 32'd5);

    // 6: restart with three words held
    mem_ready = 1'b0;
    send(2'd0, 4'hA, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 24'hFFFFFE);
    set_random_kind1(); in_valid = 1'b1; step();
    set_random_kind1(); step();
    in_valid = 1'b0;
    chk("t6_we",    32'(a_mem_we), 32'd1);
    chk("t6_head",  a_mem_wdata, 32'hABFFFFFE);
    restart = 1'b1; in_valid = 1'b1;
    #1;
    chk("t6_rs_ready", 32'(a_in_ready), 32'd0);
    step();
    restart = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6_empty",  32'(a_mem_we), 32'd0);
    chk("t6_addr_b", 32'(b_mem_addr), 32'hC);
    chk("t6_addr_a", 32'(a_mem_addr), 32'h0);
    chk("t6_wdata",  a_mem_wdata, 32'hABFFFFFE);
    chk("t6_ready",  32'(a_in_ready), 32'd1);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      restart   = ($urandom_range(0, 59) == 0);
      in_valid  = 1'($urandom);
      mem_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      set_random_kind1();
      in_kind = 2'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0: in_imm = 24'($urandom);
        1: in_imm = 24'($urandom_range(0, 4095));
        2: in_imm = 24'($urandom_range(0, 8191));
        default: in_imm = 24'h001000;
      endcase
      step();
    end
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
